// File: rtl/qam_meas_pkg.sv
// Shared types and helpers for the QAM receive-path measurement blocks.
package qam_meas_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ber_state_t;

   // Popcount of a w-bit word needs one extra bit so that an all-ones word (value w) fits.
   function automatic int popw(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/ber_popcount.sv
// Combinational count of set bits in one word; output wide enough to hold W.
module ber_popcount
   import qam_meas_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0]       word_i,
   output logic [popw(W)-1:0] ones_o
);

   localparam int PW = popw(W);

   always_comb begin
      ones_o = '0;
      for (int i = 0; i < W; i++) begin
         ones_o = ones_o + PW'(word_i[i]);
      end
   end

endmodule

// File: rtl/ber_err_counter.sv
// Bit-error-rate window controller: XOR -> popcount -> saturating accumulate, 3-edge pipeline.
// Accepts words only in RUN; done pulses once both pipeline stages have drained.
module ber_err_counter
   import qam_meas_pkg::*;
#(
   parameter int W     = 32,
   parameter int LEN_W = 16,
   parameter int ACC_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] window_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     rx_word,
   input  logic [W-1:0]     ref_word,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] err_count,
   output logic [LEN_W-1:0] word_count,
   output logic             overflow
);

   localparam int PW = popw(W);

   ber_state_t       state_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] wc_q;
   logic [ACC_W-1:0] err_q;
   logic             ovf_q;
   logic             done_q;
   logic             in_ready_q;
   logic             busy_q;
   logic             s1_vld_q;
   logic [W-1:0]     s1_dat_q;
   logic             s2_vld_q;
   logic [PW-1:0]    s2_dat_q;

   logic             accept;
   logic [PW-1:0]    pop_w;
   logic [ACC_W:0]   sum_d;
   logic [ACC_W-1:0] err_d;
   logic             sat_d;
   logic [LEN_W-1:0] wc_d;

   ber_popcount #(.W(W)) u_pop (
      .word_i (s1_dat_q),
      .ones_o (pop_w)
   );

   assign accept = in_valid & in_ready_q;

   // Extra carry bit detects an add that would pass the ceiling.
   always_comb begin
      sum_d = {1'b0, err_q} + (ACC_W+1)'(s2_dat_q);
      sat_d = sum_d[ACC_W];
      err_d = sat_d ? '1 : sum_d[ACC_W-1:0];
      wc_d  = wc_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         wc_q       <= '0;
         err_q      <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_dat_q   <= '0;
         s2_vld_q   <= 1'b0;
         s2_dat_q   <= '0;
      end else begin
         done_q   <= 1'b0;
         s1_vld_q <= accept;
         s2_vld_q <= s1_vld_q;
         if (accept)   s1_dat_q <= rx_word ^ ref_word;
         if (s1_vld_q) s2_dat_q <= pop_w;
         if (accept)   wc_q     <= wc_d;
         if (s2_vld_q) begin
            err_q <= err_d;
            if (sat_d) ovf_q <= 1'b1;
         end

         if (abort && busy_q) begin
            // Drop in-flight words; counts keep whatever had already landed.
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            err_q      <= err_q;
            ovf_q      <= ovf_q;
         end else begin
            case (state_q)
               IDLE, DONE: begin
                  if (start && !abort) begin
                     len_q <= window_len;
                     wc_q  <= '0;
                     err_q <= '0;
                     ovf_q <= 1'b0;
                     if (window_len == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q    <= RUN;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                     end
                  end
               end
               RUN: begin
                  if (accept && wc_d == len_q) begin
                     state_q    <= DRAIN;
                     in_ready_q <= 1'b0;
                  end
               end
               DRAIN: begin
                  if (!s1_vld_q && !s2_vld_q) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign in_ready   = in_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err_count  = err_q;
   assign word_count = wc_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_ber_err_counter.sv
// Randomized bench: two instances (32-bit and 6-bit accumulators) share stimulus against a window-sum model.
module tb_ber_err_counter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] window_len = '0;
   logic        in_valid = 1'b0;
   logic [31:0] rx_word = '0;
   logic [31:0] ref_word = '0;

   logic        a_in_ready, a_busy, a_done, a_ovf;
   logic [31:0] a_err;
   logic [15:0] a_wc;
   logic        b_in_ready, b_busy, b_done, b_ovf;
   logic [5:0]  b_err;
   logic [15:0] b_wc;

   ber_err_counter #(.W(32), .LEN_W(16), .ACC_W(32)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .window_len(window_len),
      .in_valid(in_valid), .in_ready(a_in_ready), .rx_word(rx_word), .ref_word(ref_word),
      .busy(a_busy), .done(a_done), .err_count(a_err), .word_count(a_wc), .overflow(a_ovf)
   );

   ber_err_counter #(.W(32), .LEN_W(16), .ACC_W(6)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .window_len(window_len),
      .in_valid(in_valid), .in_ready(b_in_ready), .rx_word(rx_word), .ref_word(ref_word),
      .busy(b_busy), .done(b_done), .err_count(b_err), .word_count(b_wc), .overflow(b_ovf)
   );

   always #5 clk = ~clk;

   int     n_chk = 0;
   int     n_err = 0;
   longint tot;
   int     nacc;
   logic [31:0] pat [4];

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint sat_val(input longint t, input int w);
      longint m;
      m = (longint'(1) << w) - 1;
      return (t > m) ? m : t;
   endfunction

   function automatic longint ovf_val(input longint t, input int w);
      return (t > ((longint'(1) << w) - 1)) ? 1 : 0;
   endfunction

   task automatic chk_results(input string tag);
      chk({tag, "_err32"}, a_err, sat_val(tot, 32));
      chk({tag, "_err6"},  b_err, sat_val(tot, 6));
      chk({tag, "_ovf32"}, a_ovf, ovf_val(tot, 32));
      chk({tag, "_ovf6"},  b_ovf, ovf_val(tot, 6));
      chk({tag, "_wc32"},  a_wc, nacc);
      chk({tag, "_wc6"},   b_wc, nacc);
   endtask

   task automatic do_start(input int len);
      start      = 1'b1;
      window_len = 16'(len);
      tot        = 0;
      nacc       = 0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // mode: 0 continuous pattern, 1 valid 1,0,0 pattern, 2/3 random gaps+data, 4 all-ones words
   task automatic run_window(input int len, input int mode, input string tag);
      int          cyc = 0;
      int          first = 0;
      int          ndone = 0;
      bit          acc;
      logic [31:0] x;
      do_start(len);
      if (len == 0) begin
         chk({tag, "_done"}, a_done, 1);
         chk({tag, "_done6"}, b_done, 1);
         chk({tag, "_rdy"}, a_in_ready, 0);
         chk_results(tag);
         @(posedge clk); #1;
         chk({tag, "_done_drop"}, a_done, 0);
         chk({tag, "_rdy_after"}, a_in_ready, 0);
         return;
      end
      while (nacc < len && cyc < len * 20 + 50) begin
         case (mode)
            0, 4:    in_valid = 1'b1;
            1:       in_valid = (cyc % 3 == 0);
            2:       in_valid = 1'($urandom_range(0, 1));
            default: in_valid = ($urandom_range(0, 3) != 0);
         endcase
         if (mode < 2)       x = pat[nacc % 4];
         else if (mode == 4) x = 32'hFFFF_FFFF;
         else                x = $urandom_range(0, 1) ? $urandom : ($urandom & $urandom & $urandom);
         ref_word = $urandom;
         rx_word  = ref_word ^ x;
         acc = in_valid && a_in_ready;
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            tot += $countones(x);
            nacc++;
         end
      end
      in_valid = 1'b0;
      chk({tag, "_accepted"}, nacc, len);
      chk({tag, "_rdy_drop"}, a_in_ready, 0);
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk); #1;
         if (a_done) begin
            ndone++;
            if (first == 0) begin
               first = e;
               chk({tag, "_done6_sync"}, b_done, 1);
               chk({tag, "_busy_at_done"}, a_busy, 0);
               chk_results(tag);
            end
         end
      end
      chk({tag, "_done_latency"}, first, 3);
      chk({tag, "_done_width"}, ndone, 1);
      chk_results({tag, "_hold"});
   endtask

   task automatic abort_test();
      int cyc = 0;
      int ndone = 0;
      bit acc;
      logic [31:0] x;
      do_start(8);
      while (nacc < 3 && cyc < 100) begin
         in_valid = 1'b1;
         // A start in RUN must not shorten the window to 2.
         start      = (cyc == 1);
         window_len = (cyc == 1) ? 16'd2 : 16'd8;
         x = $urandom;
         ref_word = $urandom;
         rx_word  = ref_word ^ x;
         acc = a_in_ready;
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
         if (acc) nacc++;
      end
      in_valid = 1'b0;
      chk("abort_accepts", nacc, 3);
      chk("run_start_ignored", a_in_ready, 1);
      abort      = 1'b1;
      start      = 1'b1;
      window_len = 16'd5;
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      chk("abort_busy", a_busy, 0);
      chk("abort_busy6", b_busy, 0);
      chk("abort_rdy", a_in_ready, 0);
      chk("abort_wc", a_wc, 3);
      chk("abort_wc6", b_wc, 3);
      for (int e = 0; e < 5; e++) begin
         if (a_done || b_done) ndone++;
         if (a_busy) ndone++;
         @(posedge clk); #1;
      end
      chk("abort_no_done", ndone, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rdy"},   a_in_ready, 0);
      chk({tag, "_busy"},  a_busy, 0);
      chk({tag, "_done"},  a_done, 0);
      chk({tag, "_err"},   a_err, 0);
      chk({tag, "_wc"},    a_wc, 0);
      chk({tag, "_ovf"},   a_ovf, 0);
      chk({tag, "_err6"},  b_err, 0);
      chk({tag, "_ovf6"},  b_ovf, 0);
   endtask

   task automatic reset_test();
      logic [31:0] x;
      do_start(8);
      x = 32'h0001_FFFF;
      in_valid = 1'b1;
      ref_word = $urandom;
      rx_word  = ref_word ^ x;
      @(posedge clk); #1;
      in_valid = 1'b0;
      tot  = 17;
      nacc = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_err", a_err, 17);
      chk("pre_rst_err6", b_err, 17);
      chk("pre_rst_busy", a_busy, 1);
      rst_n = 1'b0;
      #1;
      chk_zero("mid_rst");
      @(posedge clk); #2;
      rst_n = 1'b1;
   endtask

   initial begin
      pat[0] = 32'h0000_000F;
      pat[1] = 32'hFFFF_FFFF;
      pat[2] = 32'h8000_0001;
      pat[3] = 32'h0000_0000;
      tot  = 0;
      nacc = 0;
      #1;
      chk_zero("reset");
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_window(4, 0, "pat_cont");
      chk("pat_cont_38", tot, 38);
      run_window(4, 1, "pat_gap");
      run_window(3, 4, "sat");
      run_window(0, 0, "len0");
      abort_test();
      reset_test();
      run_window(5, 2, "post_rst");
      for (int i = 0; i < 8; i++) begin
         run_window($urandom_range(1, 12), $urandom_range(2, 3), $sformatf("rand%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
